// File: rtl/serial_pkg.sv
// Types and helpers shared by the serial shifters (parallel-to-serial and
// serial-to-parallel).
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } p2s_state_t;

    // Bit-counter width; a 1-bit word still needs a 1-bit counter.
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/parallel_to_serial.sv
// Loads a DEPTH-bit word through a load/ready handshake and shifts it out
// MSB-first, one bit per enabled clock, pulsing done after the last bit.
module parallel_to_serial
    import serial_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] data,
    input  logic             load,
    output logic             ready,
    input  logic             en,
    output logic             data_out,
    output logic             busy,
    output logic             done,
    output logic             dbg_state
);

    localparam int             CW   = cnt_width(DEPTH);
    localparam logic [CW-1:0]  LAST = CW'(DEPTH - 1);

    // Handshake: a word is taken on any edge where load && ready; while busy,
    // load is ignored and a bit is consumed on each edge where en is high.
    p2s_state_t        r_state;
    p2s_state_t        w_state_nxt;
    logic [DEPTH-1:0]  r_shreg;
    logic [DEPTH-1:0]  w_shreg_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              r_done;
    logic              w_done_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_shreg_nxt = data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (r_cnt == LAST) begin
                        // Last bit consumed: clear so nothing stale lingers.
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                        w_shreg_nxt = '0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_shreg_nxt = r_shreg << 1;
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign ready     = (r_state == IDLE);
    assign busy      = (r_state == SHIFT);
    assign data_out  = (r_state == SHIFT) ? r_shreg[DEPTH-1] : 1'b0;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench for parallel_to_serial (DEPTH=3): vector table plus
// hand-written corner sequences, with a bit scoreboard and loopback receiver.
module tb_parallel_to_serial;

    localparam int DEPTH = 3;

    logic             clk;
    logic             rst;
    logic [DEPTH-1:0] data;
    logic             load;
    logic             ready;
    logic             en;
    logic             data_out;
    logic             busy;
    logic             done;
    logic             dbg_state;

    int n_checks;
    int n_errors;

    logic [0:0] exp_q[$];

    // Loopback receiver, active-high reset of its own.
    logic             rx_rst;
    logic [DEPTH-1:0] rx_data;

    typedef struct {
        logic [DEPTH-1:0] data;
        logic [DEPTH-1:0] exp_bits;
    } vec_t;

    vec_t vecs[6];

    parallel_to_serial #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .load      (load),
        .ready     (ready),
        .en        (en),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_rst) rx_data <= '0;
        else if (en) rx_data <= {rx_data[DEPTH-2:0], data_out};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard pop: every bit consumed by an enabled edge in SHIFT.
    always @(negedge clk) begin
        if (rst && en && busy) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_bit: unexpected bit %0b, queue empty at %0t", data_out, $time);
            end else begin
                logic [0:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    n_errors++;
                    $display("FAIL sb_bit: got %0b, expected %0b at %0t", data_out, e, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word for one edge; push its bits if the bench expects acceptance.
    task automatic drive_load(input logic [DEPTH-1:0] d, input bit accept);
        load = 1'b1;
        data = d;
        if (accept) begin
            for (int i = DEPTH - 1; i >= 0; i--) exp_q.push_back(d[i]);
        end
        tick();
        load = 1'b0;
        data = $urandom_range(0, 7);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        rx_rst = 1'b1;
        load = 1'b0;
        en = 1'b0;
        data = '0;

        vecs[0] = '{data: 3'b101, exp_bits: 3'b101};
        vecs[1] = '{data: 3'b000, exp_bits: 3'b000};
        vecs[2] = '{data: 3'b111, exp_bits: 3'b111};
        vecs[3] = '{data: 3'b100, exp_bits: 3'b100};
        vecs[4] = '{data: 3'b001, exp_bits: 3'b001};
        vecs[5] = '{data: 3'b011, exp_bits: 3'b011};

        // 1. Reset with load asserted.
        tick();
        load = 1'b1;
        data = 3'b111;
        tick();
        check("rst_data_out", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_state", dbg_state, 0);
        load = 1'b0;
        rst = 1'b1;
        rx_rst = 1'b0;
        tick();
        check("rst_load_not_taken", busy, 0);

        // 2. Table: load then continuous en; done with ready on the final cycle.
        foreach (vecs[v]) begin
            drive_load(vecs[v].data, 1'b1);
            check("tbl_busy", busy, 1);
            en = 1'b1;
            for (int b = DEPTH - 1; b >= 0; b--) begin
                check("tbl_bit", data_out, vecs[v].exp_bits[b]);
                check("tbl_no_early_done", done, 0);
                tick();
            end
            en = 1'b0;
            check("tbl_done", done, 1);
            check("tbl_ready", ready, 1);
            check("tbl_idle_out", data_out, 0);
            tick();
            check("tbl_done_pulse", done, 0);
        end

        // 3. Enable gating.
        drive_load(3'b110, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("gate_hold_bit", data_out, 1);
            check("gate_hold_busy", busy, 1);
            tick();
        end
        for (int k = 0; k < DEPTH; k++) begin
            en = 1'b1;
            tick();
            en = 1'b0;
            check("gate_done", done, (k == DEPTH - 1) ? 1 : 0);
            tick();
            check("gate_gap_done", done, 0);
        end

        // 4. Load while busy ignored; back-to-back load in the done cycle.
        drive_load(3'b100, 1'b1);
        check("busy_ready", ready, 0);
        drive_load(3'b011, 1'b0);
        check("busy_load_ignored_bit", data_out, 1);
        check("busy_load_ignored_busy", busy, 1);
        en = 1'b1;
        tick();
        tick();
        tick();
        en = 1'b0;
        check("b2b_done", done, 1);
        check("b2b_ready", ready, 1);
        drive_load(3'b011, 1'b1);
        check("b2b_busy", busy, 1);
        check("b2b_first_bit", data_out, 0);
        en = 1'b1;
        tick();
        tick();
        tick();
        en = 1'b0;
        check("b2b_done2", done, 1);
        tick();

        // 5. Reset mid-word.
        drive_load(3'b111, 1'b1);
        en = 1'b1;
        tick();
        en = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.delete();
        check("midrst_data_out", data_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", ready, 1);
        check("midrst_done", done, 0);
        tick();
        check("midrst_no_done", done, 0);
        drive_load(3'b010, 1'b1);
        check("midrst_first_bit", data_out, 0);
        en = 1'b1;
        tick();
        tick();
        tick();
        en = 1'b0;
        check("midrst_done_after", done, 1);
        tick();

        // 6. Loopback into a receiver, en only while busy.
        rx_rst = 1'b1;
        tick();
        rx_rst = 1'b0;
        drive_load(3'b101, 1'b1);
        en = 1'b1;
        tick();
        tick();
        tick();
        en = 1'b0;
        check("loop_done", done, 1);
        check("loop_rx", rx_data, 3'b101);
        tick();
        tick();
        check("loop_rx_hold", rx_data, 3'b101);

        check("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
Transmit-side counterpart of the serial-to-parallel shifter. It accepts a DEPTH-bit parallel word through a load/ready handshake and shifts it out MSB-first, one bit per enabled clock. Bits appear on data_out, and en qualifies each bit for the downstream receiver. With data_out wired to the receiver's data_in and en to its en, the receiver holds the loaded word after DEPTH enabled cycles.

Parameters:
DEPTH, 3, word width in bits; legal values are DEPTH >= 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  reset; synchronous, active-low. Sampled on the rising edge of clk.
data  input  DEPTH  parallel word; sampled only when the load handshake completes.
load  input  1  request to accept data.
ready  output  1  high when a load will be accepted on this edge.
en  input  1  shift enable; when high in SHIFT, the current bit is consumed on this edge.
data_out  output  1  current serial bit; 0 when idle.
busy  output  1  high while a word is being shifted out.
done  output  1  one-cycle pulse after the final bit is consumed.

Behaviour:
- Registered state:
  - state: IDLE or SHIFT.
  - shreg: DEPTH bits.
  - cnt: width max(1, $clog2(DEPTH)).
  - done_q.
- Reset: rst=0 at a clock edge forces the following, regardless of load or en, including in the middle of a word:
  - state=IDLE, shreg=0, cnt=0, done=0.
  - Outputs after that edge: data_out=0, busy=0, ready=1, done=0.
- Combinational outputs:
  - ready = (state==IDLE).
  - busy = (state==SHIFT).
  - data_out = shreg[DEPTH-1] in SHIFT, else 0.
  - done = done_q.
- IDLE:
  - load=1 on an edge gives shreg<=data, cnt<=0, state<=SHIFT.
  - The first bit (data[DEPTH-1]) appears on data_out in the cycle after the load edge.
- SHIFT, en=0: state, shreg and cnt all hold, so data_out is stable indefinitely.
- SHIFT, en=1 and cnt<DEPTH-1: shreg<=shreg<<1 (LSB filled with 0), cnt<=cnt+1.
- SHIFT, en=1 and cnt==DEPTH-1: this is the last bit.
  - state<=IDLE and done_q<=1; shreg is cleared.
- done_q is 0 on every other edge, so done is a single-cycle pulse.
- load while in SHIFT is ignored (ready=0); the word in flight is not corrupted.
- Back-to-back words:
  - The done cycle is an IDLE cycle with ready=1, so a load in that cycle is accepted.
  - Minimum word period is DEPTH+1 cycles: 1 load cycle plus DEPTH shift cycles.
- DEPTH=1: the first enabled edge in SHIFT is the last bit.
- No X propagation: every register has a reset value, and unused shreg bits shift in 0.

Decomposition:
- Shared package serial_pkg holds:
  - typedef enum logic {IDLE, SHIFT} p2s_state_t.
  - A function that returns the counter width max(1, $clog2(depth)).
- The serial-to-parallel shifter reuses the same package when it is refactored.
- No sub-module is needed: the shift register, counter and two-state FSM all sit in one always_ff plus one always_comb.

Test Plan:
All scenarios use DEPTH=3.
1. Reset: hold rst=0 for one edge with load=1 and data=3'b111 -> after the edge data_out=0, busy=0, ready=1, done=0; the load is not taken.
2. Basic shift: load 3'b101, then en=1 continuously -> data_out reads 1, 0, 1 on the three cycles after the load; done=1 exactly on the cycle after the 3rd enabled edge; ready=1 on that same cycle.
3. Enable gating: load 3'b110, en=0 for 5 cycles -> data_out=1 and busy=1 throughout; then three single-cycle en pulses separated by gaps -> data_out reads 1, 1, 0, then done.
4. Load while busy and back-to-back: load 3'b100; pulse load with 3'b011 during SHIFT -> ignored, output 1, 0, 0; a load of 3'b011 in the done cycle is accepted -> output 0, 1, 1.
5. Reset mid-word: load 3'b111, one en edge, then rst=0 for one edge -> IDLE with data_out=0, no done pulse; a subsequent load of 3'b010 shifts out 0, 1, 0 correctly.
6. Loopback with the serial-to-parallel shifter (DEPTH=3, receiver reset separately with its own polarity): drive the receiver's en from this block's en and its data_in from data_out; load 3'b101 with en=1 only while busy -> receiver data==3'b101 when done pulses, and it stays 3'b101 after en is dropped.
